ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Pipeline stage between the 16-bit execute ALU and the data-memory/writeback stage.
- Captures the ALU result, flags, store data and writeback controls per instruction, and resolves conditional branches (BEQZ/BNEZ/BLTZ) from the ALU Zero flag and sign.
- Buffers up to two instructions in a skid buffer, so downstream back-pressure never drops or reorders an instruction while in_ready stays registered.
- Owns sticky HALT and the signed-overflow error flag.

Parameters:
- DW, 16, datapath width of result/store data/PC
- RW, 3, register-index width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream (ALU) holds a valid instruction
in_ready  out  1  stage can accept; transfer when in_valid & in_ready
in_op  in  5  ALU op code (shared package encoding)
in_alu_out  in  DW  ALU Out
in_ofl  in  1  ALU OFL
in_zero  in  1  ALU Zero (Rs == 0)
in_sign  in  1  op was signed
in_br_target  in  DW  precomputed branch target
in_st_data  in  DW  store data
in_wr_en  in  1  register writeback enable
in_wr_reg  in  RW  destination register
flush  in  1  kill all buffered entries and incoming transfer this cycle
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head
out_op, out_alu_out, out_st_data, out_wr_en, out_wr_reg  out  5/DW/DW/1/RW  head entry fields
redirect  out  1  one-cycle pulse: taken branch resolved
redirect_pc  out  DW  branch target, valid with redirect
ofl_err  out  1  sticky: signed overflow seen on ADD/SUB
halted  out  1  sticky: HALT accepted

Behaviour:
- Reset (async, rst_n low): occupancy EMPTY; out_valid=0, redirect=0, redirect_pc=0, ofl_err=0, halted=0; all out_* data fields 0; in_ready=1 one cycle after rst_n rises.
- Storage: head register H and skid register S; states EMPTY, ONE (H valid), FULL (H and S valid).
- in_ready = !S_valid & !halted, driven from registers only.
- Accept = in_valid & in_ready & !flush. Pop = out_valid & out_ready.
- State transitions:
  - EMPTY: accept -> ONE (load H).
  - ONE, accept & pop: reload H, stay ONE.
  - ONE, accept only: load S -> FULL.
  - ONE, pop only: -> EMPTY.
  - FULL: pop moves S into H -> ONE. No accept possible in FULL.
- Order is strictly FIFO. Latency: accepted in cycle N -> appears on out_* in N+1 if the stage was EMPTY or popping.
- Branch resolution at accept:
  - taken = (op==BEQZ & in_zero) | (op==BNEZ & !in_zero) | (op==BLTZ & in_alu_out[15]).
  - If taken: redirect=1 and redirect_pc=in_br_target in cycle N+1, for exactly one cycle. redirect_pc holds its value otherwise.
  - Branch entries still flow downstream with out_wr_en forced 0.
- ofl_err sets on accept of ADD or SUB with in_sign & in_ofl; it clears only on reset.
- HALT: on accept of op HALT, halted=1 from N+1 and in_ready drops. The HALT entry itself still drains downstream. Nothing clears halted except reset.
- flush:
  - Next state EMPTY; the same-cycle input is dropped and no redirect is generated for it.
  - A redirect pulse already registered in the flush cycle is still emitted.
  - flush does not clear halted or ofl_err.
  - Pop and flush in the same cycle: the pop completes (downstream sampled it) and the state still goes EMPTY.
- Unknown op codes pass through unmodified with no side effects.

Decomposition:
- Shared package alu_pkg: 5-bit op-code constants (ADD=0 ... HALT=29, BEQZ=16, BNEZ=17, BLTZ=18) shared with the ALU and decoder, plus the packed entry struct {op, alu_out, st_data, wr_en, wr_reg}.
- One natural sub-module: ex_skid_buf, the two-entry H/S buffer with its occupancy state machine. Branch/halt/overflow logic stays in the top.

Test Plan:
- Streaming with out_ready=1: ADD alu_out=0x0003, then OR 0x00F0, then AND 0x0010 on consecutive cycles -> the same three appear one cycle later each; in_ready never drops.
- Back-pressure: out_ready=0, push 0x1111 then 0x2222 -> FULL and in_ready=0; raise out_ready -> 0x1111 then 0x2222 in order, and in_ready returns 1 the cycle after the first pop.
- Branches:
  - BEQZ, zero=1, target=0x0040 -> redirect pulse 1 cycle, redirect_pc=0x0040.
  - BNEZ, zero=1 -> no redirect.
  - BLTZ with alu_out=0xFFFF, target=0x0100 -> redirect to 0x0100; out_wr_en=0.
- Overflow: signed ADD with in_ofl=1 -> ofl_err=1 and stays 1; unsigned ADD with in_ofl=1 alone leaves ofl_err=0.
- Flush and reset: while FULL, assert flush together with in_valid carrying a taken BEQZ -> next cycle out_valid=0 and no redirect. Drop rst_n mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
- HALT: accept HALT -> halted=1 and in_ready=0 the next cycle; the HALT entry is popped downstream, and later in_valid pulses are ignored.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants used by the decoder, the ALU and the
// EX/MEM stage, plus the packed pipeline entry carried from EX to MEM.
package alu_pkg;

    localparam int unsigned DataWidth = 16;
    localparam int unsigned RegWidth  = 3;
    localparam int unsigned OpWidth   = 5;

    localparam logic [OpWidth-1:0] OpAdd  = 5'd0;
    localparam logic [OpWidth-1:0] OpSub  = 5'd1;
    localparam logic [OpWidth-1:0] OpAnd  = 5'd2;
    localparam logic [OpWidth-1:0] OpOr   = 5'd3;
    localparam logic [OpWidth-1:0] OpXor  = 5'd4;
    localparam logic [OpWidth-1:0] OpBeqz = 5'd16;
    localparam logic [OpWidth-1:0] OpBnez = 5'd17;
    localparam logic [OpWidth-1:0] OpBltz = 5'd18;
    localparam logic [OpWidth-1:0] OpHalt = 5'd29;

    typedef struct packed {
        logic [OpWidth-1:0]   op;
        logic [DataWidth-1:0] alu_out;
        logic [DataWidth-1:0] st_data;
        logic                 wr_en;
        logic [RegWidth-1:0]  wr_reg;
    } entry_t;

    function automatic logic is_branch(input logic [OpWidth-1:0] op);
        return (op == OpBeqz) || (op == OpBnez) || (op == OpBltz);
    endfunction

endpackage

// File: rtl/ex_skid_buf.sv
// Two-entry skid buffer (head H, skid S) with EMPTY/ONE/FULL occupancy.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   push            load in_entry this cycle (caller guarantees not FULL)
//   flush           drop everything, next state EMPTY (pop still completes)
//   out_ready       downstream accepts head
//   in_entry        entry to load
//   out_valid       head valid
//   out_entry       head entry
//   full            S valid (registered)
//   full_next       S valid next cycle, for building registered ready upstream
module ex_skid_buf
    import alu_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   flush,
    input  logic   out_ready,
    input  entry_t in_entry,
    output logic   out_valid,
    output entry_t out_entry,
    output logic   full,
    output logic   full_next
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e state_q, state_d;
    entry_t h_q, h_d;
    entry_t s_q, s_d;
    logic   pop;

    assign out_valid = (state_q != StEmpty);
    assign full      = (state_q == StFull);
    assign full_next = (state_d == StFull);
    assign out_entry = h_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        s_d     = s_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        h_d     = in_entry;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        h_d = in_entry;
                    end else if (push) begin
                        s_d     = in_entry;
                        state_d = StFull;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    // Upstream ready is low here, so only a pop can happen.
                    if (pop) begin
                        h_d     = s_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            h_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            s_q     <= s_d;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: buffers ALU results in a two-entry skid buffer,
// resolves BEQZ/BNEZ/BLTZ at accept, and holds sticky HALT / overflow flags.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready             upstream handshake (in_ready registered)
//   in_op..in_wr_reg              ALU result, flags and writeback controls
//   flush                         drop buffered entries and this cycle's input
//   out_valid/out_ready           downstream handshake
//   out_op..out_wr_reg            head entry fields
//   redirect/redirect_pc          one-cycle taken-branch pulse and target
//   ofl_err                       sticky signed overflow on ADD/SUB
//   halted                        sticky HALT accepted
module ex_mem_stage
    import alu_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_op,
    input  logic [DW-1:0] in_alu_out,
    input  logic          in_ofl,
    input  logic          in_zero,
    input  logic          in_sign,
    input  logic [DW-1:0] in_br_target,
    input  logic [DW-1:0] in_st_data,
    input  logic          in_wr_en,
    input  logic [RW-1:0] in_wr_reg,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [4:0]    out_op,
    output logic [DW-1:0] out_alu_out,
    output logic [DW-1:0] out_st_data,
    output logic          out_wr_en,
    output logic [RW-1:0] out_wr_reg,
    output logic          redirect,
    output logic [DW-1:0] redirect_pc,
    output logic          ofl_err,
    output logic          halted
);

    logic          accept;
    logic          taken;
    logic          full;
    logic          full_next;
    entry_t        in_entry;
    entry_t        head;

    logic          in_ready_q, in_ready_d;
    logic          redirect_q, redirect_d;
    logic [DW-1:0] redirect_pc_q, redirect_pc_d;
    logic          ofl_err_q, ofl_err_d;
    logic          halted_q, halted_d;

    assign accept = in_valid & in_ready_q & ~flush;

    always_comb begin
        taken = ((in_op == OpBeqz) &  in_zero) |
                ((in_op == OpBnez) & ~in_zero) |
                ((in_op == OpBltz) &  in_alu_out[DW-1]);

        in_entry.op      = in_op;
        in_entry.alu_out = in_alu_out;
        in_entry.st_data = in_st_data;
        // Branches flow downstream but must never write a register.
        in_entry.wr_en   = in_wr_en & ~is_branch(in_op);
        in_entry.wr_reg  = in_wr_reg;

        redirect_d    = accept & taken;
        redirect_pc_d = (accept & taken) ? in_br_target : redirect_pc_q;
        ofl_err_d     = ofl_err_q |
                        (accept & ((in_op == OpAdd) | (in_op == OpSub)) & in_sign & in_ofl);
        halted_d      = halted_q | (accept & (in_op == OpHalt));
        // Ready is registered: computed from next occupancy and next halt state.
        in_ready_d    = ~full_next & ~halted_d;
    end

    ex_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .flush     (flush),
        .out_ready (out_ready),
        .in_entry  (in_entry),
        .out_valid (out_valid),
        .out_entry (head),
        .full      (full),
        .full_next (full_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q    <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            ofl_err_q     <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            in_ready_q    <= in_ready_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            ofl_err_q     <= ofl_err_d;
            halted_q      <= halted_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign ofl_err     = ofl_err_q;
    assign halted      = halted_q;

    assign out_op      = head.op;
    assign out_alu_out = head.alu_out;
    assign out_st_data = head.st_data;
    assign out_wr_en   = head.wr_en;
    assign out_wr_reg  = head.wr_reg;

    // S occupancy is already folded into in_ready_q; keep the flag observable.
    logic unused_full;
    assign unused_full = full;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [15:0] in_alu_out;
    logic        in_ofl;
    logic        in_zero;
    logic        in_sign;
    logic [15:0] in_br_target;
    logic [15:0] in_st_data;
    logic        in_wr_en;
    logic [2:0]  in_wr_reg;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_op;
    logic [15:0] out_alu_out;
    logic [15:0] out_st_data;
    logic        out_wr_en;
    logic [2:0]  out_wr_reg;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        ofl_err;
    logic        halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.DW(16), .RW(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_alu_out   (in_alu_out),
        .in_ofl       (in_ofl),
        .in_zero      (in_zero),
        .in_sign      (in_sign),
        .in_br_target (in_br_target),
        .in_st_data   (in_st_data),
        .in_wr_en     (in_wr_en),
        .in_wr_reg    (in_wr_reg),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_op       (out_op),
        .out_alu_out  (out_alu_out),
        .out_st_data  (out_st_data),
        .out_wr_en    (out_wr_en),
        .out_wr_reg   (out_wr_reg),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .ofl_err      (ofl_err),
        .halted       (halted)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [4:0] op, input logic [15:0] alu,
                          input logic ofl, input logic zero, input logic sign,
                          input logic [15:0] tgt, input logic wen, input logic [2:0] wreg);
        in_valid     = v;
        in_op        = op;
        in_alu_out   = alu;
        in_ofl       = ofl;
        in_zero      = zero;
        in_sign      = sign;
        in_br_target = tgt;
        in_st_data   = alu ^ 16'hA5A5;
        in_wr_en     = wen;
        in_wr_reg    = wreg;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        idle();
        #22;
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_redirect", {31'b0, redirect}, 32'd0);
        check_eq("rst_redirect_pc", {16'b0, redirect_pc}, 32'd0);
        check_eq("rst_ofl_err", {31'b0, ofl_err}, 32'd0);
        check_eq("rst_halted", {31'b0, halted}, 32'd0);
        check_eq("rst_out_alu_out", {16'b0, out_alu_out}, 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("ready_after_rst", {31'b0, in_ready}, 32'd1);

        // Streaming ADD/OR/AND with out_ready=1
        set_in(1'b1, 5'd0, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd5);
        tick();
        check_eq("s1_valid", {31'b0, out_valid}, 32'd1);
        check_eq("s1_alu", {16'b0, out_alu_out}, 32'h0003);
        check_eq("s1_st", {16'b0, out_st_data}, 32'h0003 ^ 32'hA5A5);
        check_eq("s1_wr_en", {31'b0, out_wr_en}, 32'd1);
        check_eq("s1_wr_reg", {29'b0, out_wr_reg}, 32'd5);
        check_eq("s1_ready", {31'b0, in_ready}, 32'd1);
        set_in(1'b1, 5'd3, 16'h00F0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd1);
        tick();
        check_eq("s2_alu", {16'b0, out_alu_out}, 32'h00F0);
        check_eq("s2_op", {27'b0, out_op}, 32'd3);
        check_eq("s2_ready", {31'b0, in_ready}, 32'd1);
        set_in(1'b1, 5'd2, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd2);
        tick();
        check_eq("s3_alu", {16'b0, out_alu_out}, 32'h0010);
        check_eq("s3_ready", {31'b0, in_ready}, 32'd1);
        idle();
        tick();
        check_eq("s_drained", {31'b0, out_valid}, 32'd0);

        // Back-pressure
        out_ready = 1'b0;
        set_in(1'b1, 5'd0, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd1);
        tick();
        check_eq("bp1_alu", {16'b0, out_alu_out}, 32'h1111);
        check_eq("bp1_ready", {31'b0, in_ready}, 32'd1);
        set_in(1'b1, 5'd0, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd2);
        tick();
        check_eq("bp_full_ready", {31'b0, in_ready}, 32'd0);
        check_eq("bp_full_head", {16'b0, out_alu_out}, 32'h1111);
        idle();
        out_ready = 1'b1;
        tick();
        check_eq("bp_pop2_alu", {16'b0, out_alu_out}, 32'h2222);
        check_eq("bp_ready_back", {31'b0, in_ready}, 32'd1);
        tick();
        check_eq("bp_drained", {31'b0, out_valid}, 32'd0);

        // Branches
        set_in(1'b1, 5'd16, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0040, 1'b1, 3'd3);
        tick();
        check_eq("beqz_redirect", {31'b0, redirect}, 32'd1);
        check_eq("beqz_pc", {16'b0, redirect_pc}, 32'h0040);
        check_eq("beqz_wr_en", {31'b0, out_wr_en}, 32'd0);
        idle();
        tick();
        check_eq("beqz_pulse_end", {31'b0, redirect}, 32'd0);
        check_eq("beqz_pc_hold", {16'b0, redirect_pc}, 32'h0040);
        set_in(1'b1, 5'd17, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0080, 1'b0, 3'd0);
        tick();
        check_eq("bnez_no_redirect", {31'b0, redirect}, 32'd0);
        check_eq("bnez_pc_hold", {16'b0, redirect_pc}, 32'h0040);
        set_in(1'b1, 5'd18, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b1, 3'd4);
        tick();
        check_eq("bltz_redirect", {31'b0, redirect}, 32'd1);
        check_eq("bltz_pc", {16'b0, redirect_pc}, 32'h0100);
        check_eq("bltz_wr_en", {31'b0, out_wr_en}, 32'd0);
        idle();
        tick();

        // Overflow
        set_in(1'b1, 5'd0, 16'h8000, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 3'd1);
        tick();
        check_eq("ofl_unsigned", {31'b0, ofl_err}, 32'd0);
        set_in(1'b1, 5'd0, 16'h8000, 1'b1, 1'b0, 1'b1, 16'h0, 1'b1, 3'd1);
        tick();
        check_eq("ofl_signed", {31'b0, ofl_err}, 32'd1);
        idle();
        tick();
        check_eq("ofl_sticky", {31'b0, ofl_err}, 32'd1);

        // Flush while FULL with a taken BEQZ on the input
        out_ready = 1'b0;
        set_in(1'b1, 5'd4, 16'hAAAA, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd1);
        tick();
        set_in(1'b1, 5'd4, 16'hBBBB, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd2);
        tick();
        check_eq("fl_full_ready", {31'b0, in_ready}, 32'd0);
        set_in(1'b1, 5'd16, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0200, 1'b0, 3'd0);
        flush = 1'b1;
        tick();
        check_eq("fl_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("fl_no_redirect", {31'b0, redirect}, 32'd0);
        check_eq("fl_pc_hold", {16'b0, redirect_pc}, 32'h0100);
        check_eq("fl_ofl_kept", {31'b0, ofl_err}, 32'd1);
        check_eq("fl_ready", {31'b0, in_ready}, 32'd1);
        // Flush with ready high: taken branch dropped, no redirect
        tick();
        check_eq("fl2_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("fl2_no_redirect", {31'b0, redirect}, 32'd0);
        flush = 1'b0;
        idle();
        out_ready = 1'b1;
        tick();

        // Asynchronous reset mid-stream
        set_in(1'b1, 5'd18, 16'h8001, 1'b0, 1'b0, 1'b0, 16'h0300, 1'b1, 3'd6);
        tick();
        check_eq("ar_pre_valid", {31'b0, out_valid}, 32'd1);
        check_eq("ar_pre_redirect", {31'b0, redirect}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("ar_redirect", {31'b0, redirect}, 32'd0);
        check_eq("ar_pc", {16'b0, redirect_pc}, 32'd0);
        check_eq("ar_ofl", {31'b0, ofl_err}, 32'd0);
        check_eq("ar_alu", {16'b0, out_alu_out}, 32'd0);
        check_eq("ar_wr_reg", {29'b0, out_wr_reg}, 32'd0);
        check_eq("ar_ready", {31'b0, in_ready}, 32'd0);
        idle();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("ar_ready_back", {31'b0, in_ready}, 32'd1);

        // HALT
        out_ready = 1'b0;
        set_in(1'b1, 5'd29, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
        tick();
        check_eq("halt_flag", {31'b0, halted}, 32'd1);
        check_eq("halt_ready", {31'b0, in_ready}, 32'd0);
        check_eq("halt_head_op", {27'b0, out_op}, 32'd29);
        set_in(1'b1, 5'd0, 16'h5555, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd7);
        out_ready = 1'b1;
        tick();
        check_eq("halt_drained", {31'b0, out_valid}, 32'd0);
        tick();
        check_eq("halt_ignored", {31'b0, out_valid}, 32'd0);
        check_eq("halt_sticky", {31'b0, halted}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("halt_after_flush", {31'b0, halted}, 32'd1);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
